// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and constants for the pipeline hazard controller
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MD_WAIT = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    LOAD_USE = 2'd1,
    MULDIV   = 2'd2,
    REDIRECT = 2'd3
  } stall_reason_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Purpose  : ID/EX hazard inputs and IF/ID + ID/EX stall/flush controls
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_pkg::*;

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_reads_hilo;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_muldiv;
  logic             ex_redirect;
  logic             perf_clr;

  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             id_ex_flush;
  logic             muldiv_busy;
  stall_reason_t    stall_reason;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: supplies instruction info, consumes controls
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo,
           ex_mem_read, ex_rt, ex_muldiv, ex_redirect, perf_clr,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble, id_ex_flush,
           muldiv_busy, stall_reason, stall_cnt, flush_cnt
  );

  // Hazard controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo,
           ex_mem_read, ex_rt, ex_muldiv, ex_redirect, perf_clr,
    output pc_hold, if_id_hold, if_id_flush, id_ex_bubble, id_ex_flush,
           muldiv_busy, stall_reason, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Saturating up-counter with synchronous clear (clear wins)
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_inc,
  input  wire logic             i_clr,
  output logic      [WIDTH-1:0] o_count
);

  // Count up, stick at all-ones, clear takes priority over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Load-use / mult-div / redirect hazard control for a 5-stage
//             MIPS pipeline, with post-reset flush window and perf counters
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT  = 4,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  hazard_ctrl_if.slave  bus
);

  localparam logic [3:0] C_MD_LAT    = 4'(MULDIV_LAT);
  localparam logic [3:0] C_INIT_CYCS = 4'(INIT_CYCLES);

  hz_state_t     r_state;
  logic [3:0]    r_init_cnt;
  logic [3:0]    r_md_cnt;

  logic          w_busy;
  logic          w_load_use;
  logic          w_md_hazard;
  logic          w_hold;
  logic          w_flush;
  logic          w_redirect_act;
  stall_reason_t w_reason;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  assign w_busy     = (r_md_cnt != 4'd0);
  assign w_load_use = bus.ex_mem_read && (bus.ex_rt != REG_ZERO) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));
  // A mult/div entering EX this cycle already blocks a HI/LO reader in ID
  assign w_md_hazard = bus.id_reads_hilo && (w_busy || bus.ex_muldiv);

  // Same-cycle control decode: init window, then redirect > load-use > mult/div
  always_comb begin
    w_hold         = 1'b0;
    w_flush        = 1'b0;
    w_redirect_act = 1'b0;
    w_reason       = NONE;
    if (r_state == INIT) begin
      w_flush = 1'b1;
    end else if (bus.ex_redirect) begin
      w_flush        = 1'b1;
      w_redirect_act = 1'b1;
      w_reason       = REDIRECT;
    end else if (w_load_use) begin
      w_hold   = 1'b1;
      w_reason = LOAD_USE;
    end else if (w_md_hazard) begin
      w_hold   = 1'b1;
      w_reason = MULDIV;
    end
  end

  // Phase tracking: init countdown, then mult/div latency countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= INIT;
      r_init_cnt <= C_INIT_CYCS;
      r_md_cnt   <= 4'd0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt - 4'd1;
          if (r_init_cnt == 4'd1) r_state <= RUN;
        end
        RUN: begin
          if (bus.ex_muldiv) begin
            r_md_cnt <= C_MD_LAT;
            r_state  <= MD_WAIT;
          end
        end
        MD_WAIT: begin
          // A redirect does not cancel: the mult/div is older than the branch
          if (bus.ex_muldiv) begin
            r_md_cnt <= C_MD_LAT;
          end else begin
            r_md_cnt <= r_md_cnt - 4'd1;
            if (r_md_cnt == 4'd1) r_state <= RUN;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_hold),
    .i_clr   (bus.perf_clr),
    .o_count (w_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_redirect_act),
    .i_clr   (bus.perf_clr),
    .o_count (w_flush_cnt)
  );

  assign bus.pc_hold      = w_hold;
  assign bus.if_id_hold   = w_hold;
  assign bus.id_ex_bubble = w_hold;
  assign bus.if_id_flush  = w_flush;
  assign bus.id_ex_flush  = w_flush;
  assign bus.muldiv_busy  = w_busy;
  assign bus.stall_reason = w_reason;
  assign bus.stall_cnt    = w_stall_cnt;
  assign bus.flush_cnt    = w_flush_cnt;

endmodule
`default_nettype wire
